// File: rtl/operand_fetch_seq.sv
// operand_fetch_seq
// Sequencer wrapped around a 16x32 register file that has only one read
// port (A) and one write port (C). One instruction is taken at a time:
// its source registers are read one after the other through port A, the
// operands are handed to the ALU with a valid/ready handshake, and the ALU
// result is written back through port C.
//
// Instruction layout:
//   [31:27] opcode
//   [26:23] ra  destination register
//   [22:19] rb  first source register
//   [18:15] rc  second source register (R-format only)
//   [18:0]  C   signed immediate (I-format only)
//
// Opcodes 0..R_OP_HI are R-format (two register operands), opcodes
// IMM_OP_LO..IMM_OP_HI are I-format (register plus sign-extended
// immediate). Any other opcode is dropped with a one-cycle out_illegal pulse.
//
// Every output comes straight from a flop. Each value is loaded on the edge
// that enters the state where it has to be visible. For example, out_Aselect
// is set to rb on the accept edge so the register file can return rb's
// contents during READ_B.

module operand_fetch_seq #(
   parameter int         DATA_W    = 32,
   parameter int         SEL_W     = 4,
   parameter int         IMM_W     = 19,
   parameter logic [4:0] IMM_OP_LO = 5'd12,
   parameter logic [4:0] IMM_OP_HI = 5'd14,
   parameter logic [4:0] R_OP_HI   = 5'd11
) (
   input  logic              in_clk,
   input  logic              in_clr,
   input  logic [31:0]       in_instr,
   input  logic              in_instr_valid,
   output logic              out_instr_ready,
   output logic [SEL_W-1:0]  out_Aselect,
   input  logic [DATA_W-1:0] in_Adata,
   output logic [DATA_W-1:0] out_opA,
   output logic [DATA_W-1:0] out_opB,
   output logic [4:0]        out_opcode,
   output logic              out_op_valid,
   input  logic              in_op_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_result_valid,
   output logic [DATA_W-1:0] out_Cdata,
   output logic [SEL_W-1:0]  out_Cselect,
   output logic              out_write,
   output logic              out_illegal
);

   typedef enum logic [2:0] {
      IDLE,
      READ_B,
      READ_C,
      ISSUE,
      WAIT_RES,
      WRITE
   } state_t;

   state_t state;

   // Fields of the incoming instruction, split out for readability.
   logic [4:0]       new_opcode;
   logic [SEL_W-1:0] new_ra;
   logic [SEL_W-1:0] new_rb;
   logic [SEL_W-1:0] new_rc;
   logic [IMM_W-1:0] new_imm;
   logic             new_is_r;
   logic             new_is_i;

   // Fields kept from the accepted instruction while it is being worked on.
   logic [SEL_W-1:0] ra_q;
   logic [SEL_W-1:0] rc_q;
   logic [IMM_W-1:0] imm_q;
   logic             is_imm_q;

   // Immediate widened to the operand width by copying its sign bit.
   logic [DATA_W-1:0] imm_sext;

   assign new_opcode = in_instr[31:27];
   assign new_ra     = in_instr[26:23];
   assign new_rb     = in_instr[22:19];
   assign new_rc     = in_instr[18:15];
   assign new_imm    = in_instr[18:0];

   // Work out the instruction format from the opcode range it falls in.
   always_comb begin
      new_is_r = 1'b0;
      new_is_i = 1'b0;
      if (new_opcode <= R_OP_HI) begin
         new_is_r = 1'b1;
      end
      if ((new_opcode >= IMM_OP_LO) && (new_opcode <= IMM_OP_HI)) begin
         new_is_i = 1'b1;
      end
   end

   assign imm_sext = {{(DATA_W - IMM_W){imm_q[IMM_W-1]}}, imm_q};

   // Sequencer FSM. It owns every registered output and every stored
   // instruction field. Reset drops any instruction that is in flight.
   always_ff @(posedge in_clk or negedge in_clr) begin
      if (!in_clr) begin
         state           <= IDLE;
         out_instr_ready <= 1'b1;
         out_Aselect     <= '0;
         out_opA         <= '0;
         out_opB         <= '0;
         out_opcode      <= '0;
         out_op_valid    <= 1'b0;
         out_Cdata       <= '0;
         out_Cselect     <= '0;
         out_write       <= 1'b0;
         out_illegal     <= 1'b0;
         ra_q            <= '0;
         rc_q            <= '0;
         imm_q           <= '0;
         is_imm_q        <= 1'b0;
      end else begin
         // out_write and out_illegal are single-cycle strobes, so they
         // drop again on the next edge unless a state sets them again.
         out_write   <= 1'b0;
         out_illegal <= 1'b0;

         case (state)
            IDLE: begin
               if (in_instr_valid) begin
                  out_opcode <= new_opcode;
                  ra_q       <= new_ra;
                  rc_q       <= new_rc;
                  imm_q      <= new_imm;
                  if (new_is_r || new_is_i) begin
                     is_imm_q        <= new_is_i;
                     out_Aselect     <= new_rb;
                     out_instr_ready <= 1'b0;
                     state           <= READ_B;
                  end else begin
                     out_illegal <= 1'b1;
                  end
               end
            end

            READ_B: begin
               out_opA <= in_Adata;
               if (is_imm_q) begin
                  // I-format needs only one register read. The second
                  // operand is the immediate.
                  out_opB      <= imm_sext;
                  out_Aselect  <= '0;
                  out_op_valid <= 1'b1;
                  state        <= ISSUE;
               end else begin
                  out_Aselect <= rc_q;
                  state       <= READ_C;
               end
            end

            READ_C: begin
               out_opB      <= in_Adata;
               out_Aselect  <= '0;
               out_op_valid <= 1'b1;
               state        <= ISSUE;
            end

            ISSUE: begin
               // Operands and opcode stay put until the ALU takes them.
               // A result strobe seen here is not ours yet, so it is ignored.
               if (in_op_ready) begin
                  out_op_valid <= 1'b0;
                  state        <= WAIT_RES;
               end
            end

            WAIT_RES: begin
               if (in_result_valid) begin
                  out_Cdata   <= in_result;
                  out_Cselect <= ra_q;
                  out_write   <= (ra_q != '0);
                  state       <= WRITE;
               end
            end

            WRITE: begin
               out_instr_ready <= 1'b1;
               state           <= IDLE;
            end

            default: begin
               out_instr_ready <= 1'b1;
               out_op_valid    <= 1'b0;
               out_Aselect     <= '0;
               state           <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_operand_fetch_seq.sv
// tb_operand_fetch_seq
// Directed bench for operand_fetch_seq. A small register-file array answers
// port A combinationally. The bench itself plays the ALU by driving
// in_op_ready and in_result by hand. Inputs change and outputs are sampled on
// the falling clock edge, half a cycle away from the active edge.

module tb_operand_fetch_seq;

   logic        in_clk;
   logic        in_clr;
   logic [31:0] in_instr;
   logic        in_instr_valid;
   logic        out_instr_ready;
   logic [3:0]  out_Aselect;
   logic [31:0] in_Adata;
   logic [31:0] out_opA;
   logic [31:0] out_opB;
   logic [4:0]  out_opcode;
   logic        out_op_valid;
   logic        in_op_ready;
   logic [31:0] in_result;
   logic        in_result_valid;
   logic [31:0] out_Cdata;
   logic [3:0]  out_Cselect;
   logic        out_write;
   logic        out_illegal;

   logic [31:0] regs [16];

   int total;
   int bad;

   operand_fetch_seq dut (
      .in_clk          (in_clk),
      .in_clr          (in_clr),
      .in_instr        (in_instr),
      .in_instr_valid  (in_instr_valid),
      .out_instr_ready (out_instr_ready),
      .out_Aselect     (out_Aselect),
      .in_Adata        (in_Adata),
      .out_opA         (out_opA),
      .out_opB         (out_opB),
      .out_opcode      (out_opcode),
      .out_op_valid    (out_op_valid),
      .in_op_ready     (in_op_ready),
      .in_result       (in_result),
      .in_result_valid (in_result_valid),
      .out_Cdata       (out_Cdata),
      .out_Cselect     (out_Cselect),
      .out_write       (out_write),
      .out_illegal     (out_illegal)
   );

   assign in_Adata = regs[out_Aselect];

   // Free-running clock with a 10 ns period.
   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   // Safety net in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] mkR(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
      return {op, ra, rb, rc, 15'd0};
   endfunction

   function automatic logic [31:0] mkI(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [18:0] c);
      return {op, ra, rb, c};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Runs one instruction with no backpressure and checks it cycle by cycle.
   // The task is entered and left on a falling edge with the DUT in IDLE.
   task automatic applyStimulus(input string nm, input logic [31:0] instr,
                                input bit two_reads, input logic [3:0] sel_b,
                                input logic [3:0] sel_c, input logic [31:0] exp_a,
                                input logic [31:0] exp_b, input logic [31:0] res,
                                input bit exp_wr, input logic [3:0] exp_csel);
      checkOutput({nm, "_ready_idle"}, 32'(out_instr_ready), 32'd1);
      in_instr       = instr;
      in_instr_valid = 1'b1;
      @(negedge in_clk);
      in_instr_valid = 1'b0;
      checkOutput({nm, "_selb"}, 32'(out_Aselect), 32'(sel_b));
      checkOutput({nm, "_ready_busy"}, 32'(out_instr_ready), 32'd0);
      checkOutput({nm, "_opv_early1"}, 32'(out_op_valid), 32'd0);
      if (two_reads) begin
         @(negedge in_clk);
         checkOutput({nm, "_selc"}, 32'(out_Aselect), 32'(sel_c));
         checkOutput({nm, "_opv_early2"}, 32'(out_op_valid), 32'd0);
      end
      @(negedge in_clk);
      checkOutput({nm, "_opv"}, 32'(out_op_valid), 32'd1);
      checkOutput({nm, "_opA"}, out_opA, exp_a);
      checkOutput({nm, "_opB"}, out_opB, exp_b);
      checkOutput({nm, "_opcode"}, 32'(out_opcode), 32'(instr[31:27]));
      checkOutput({nm, "_sel_idle"}, 32'(out_Aselect), 32'd0);
      in_op_ready = 1'b1;
      @(negedge in_clk);
      in_op_ready = 1'b0;
      checkOutput({nm, "_opv_drop"}, 32'(out_op_valid), 32'd0);
      checkOutput({nm, "_wr_wait"}, 32'(out_write), 32'd0);
      in_result       = res;
      in_result_valid = 1'b1;
      @(negedge in_clk);
      in_result_valid = 1'b0;
      checkOutput({nm, "_write"}, 32'(out_write), 32'(exp_wr));
      checkOutput({nm, "_cdata"}, out_Cdata, res);
      checkOutput({nm, "_csel"}, 32'(out_Cselect), 32'(exp_csel));
      @(negedge in_clk);
      checkOutput({nm, "_write_off"}, 32'(out_write), 32'd0);
      checkOutput({nm, "_ready_back"}, 32'(out_instr_ready), 32'd1);
   endtask

   initial begin
      total           = 0;
      bad             = 0;
      in_clr          = 1'b0;
      in_instr        = '0;
      in_instr_valid  = 1'b0;
      in_op_ready     = 1'b0;
      in_result       = '0;
      in_result_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         regs[i] = 32'd0;
      end
      regs[1] = 32'd5;
      regs[2] = 32'd7;

      // Outputs while reset is held.
      repeat (2) @(negedge in_clk);
      checkOutput("rst_ready", 32'(out_instr_ready), 32'd1);
      checkOutput("rst_opv", 32'(out_op_valid), 32'd0);
      checkOutput("rst_write", 32'(out_write), 32'd0);
      checkOutput("rst_illegal", 32'(out_illegal), 32'd0);
      checkOutput("rst_asel", 32'(out_Aselect), 32'd0);
      checkOutput("rst_opA", out_opA, 32'd0);
      checkOutput("rst_opB", out_opB, 32'd0);
      checkOutput("rst_cdata", out_Cdata, 32'd0);
      checkOutput("rst_csel", 32'(out_Cselect), 32'd0);
      checkOutput("rst_opcode", 32'(out_opcode), 32'd0);
      in_clr = 1'b1;
      @(negedge in_clk);

      // R-format: R3 <= R1 op R2. 5 and 7 in, result 12 out.
      applyStimulus("r3", mkR(5'd3, 4'd3, 4'd1, 4'd2), 1'b1, 4'd1, 4'd2,
                    32'd5, 32'd7, 32'd12, 1'b1, 4'd3);

      // I-format with a negative immediate, then a small positive one.
      applyStimulus("i_neg", mkI(5'd12, 4'd4, 4'd1, 19'h7FFFF), 1'b0, 4'd1, 4'd0,
                    32'd5, 32'hFFFF_FFFF, 32'h0000_ABCD, 1'b1, 4'd4);
      applyStimulus("i_pos", mkI(5'd12, 4'd4, 4'd1, 19'h00005), 1'b0, 4'd1, 4'd0,
                    32'd5, 32'h0000_0005, 32'h0000_0010, 1'b1, 4'd4);

      // ra = 0 and rb = 0: the whole sequence runs, but nothing is written.
      applyStimulus("r0", mkI(5'd13, 4'd0, 4'd0, 19'h00003), 1'b0, 4'd0, 4'd0,
                    32'd0, 32'd3, 32'd55, 1'b0, 4'd0);

      // ALU backpressure in ISSUE, plus a stray result pulse that is ignored.
      in_instr       = mkR(5'd1, 4'd5, 4'd2, 4'd1);
      in_instr_valid = 1'b1;
      @(negedge in_clk);
      in_instr_valid = 1'b0;
      @(negedge in_clk);
      @(negedge in_clk);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("bp_opv%0d", i), 32'(out_op_valid), 32'd1);
         checkOutput($sformatf("bp_opA%0d", i), out_opA, 32'd7);
         checkOutput($sformatf("bp_opB%0d", i), out_opB, 32'd5);
         in_result       = 32'hDEAD_BEEF;
         in_result_valid = (i == 1);
         @(negedge in_clk);
      end
      checkOutput("bp_opv_held", 32'(out_op_valid), 32'd1);
      checkOutput("bp_no_write", 32'(out_write), 32'd0);
      in_op_ready     = 1'b1;
      in_result_valid = 1'b1;
      @(negedge in_clk);
      in_op_ready     = 1'b0;
      in_result_valid = 1'b0;
      checkOutput("bp_opv_drop", 32'(out_op_valid), 32'd0);
      checkOutput("bp_accept_wr", 32'(out_write), 32'd0);
      @(negedge in_clk);
      checkOutput("bp_still_wait", 32'(out_write), 32'd0);
      checkOutput("bp_wait_ready", 32'(out_instr_ready), 32'd0);
      in_result       = 32'd99;
      in_result_valid = 1'b1;
      @(negedge in_clk);
      in_result_valid = 1'b0;
      checkOutput("bp_write", 32'(out_write), 32'd1);
      checkOutput("bp_cdata", out_Cdata, 32'd99);
      checkOutput("bp_csel", 32'(out_Cselect), 32'd5);
      @(negedge in_clk);
      checkOutput("bp_ready_back", 32'(out_instr_ready), 32'd1);

      // Unsupported opcode: one illegal pulse and no register read.
      in_instr       = mkR(5'd20, 4'd1, 4'd2, 4'd1);
      in_instr_valid = 1'b1;
      @(negedge in_clk);
      in_instr_valid = 1'b0;
      checkOutput("ill_pulse", 32'(out_illegal), 32'd1);
      checkOutput("ill_asel", 32'(out_Aselect), 32'd0);
      checkOutput("ill_ready", 32'(out_instr_ready), 32'd1);
      checkOutput("ill_opv", 32'(out_op_valid), 32'd0);
      @(negedge in_clk);
      checkOutput("ill_pulse_end", 32'(out_illegal), 32'd0);
      checkOutput("ill_ready2", 32'(out_instr_ready), 32'd1);

      // Asynchronous reset while waiting for the result.
      in_instr       = mkR(5'd2, 4'd7, 4'd1, 4'd2);
      in_instr_valid = 1'b1;
      @(negedge in_clk);
      in_instr_valid = 1'b0;
      @(negedge in_clk);
      @(negedge in_clk);
      in_op_ready = 1'b1;
      @(negedge in_clk);
      in_op_ready = 1'b0;
      checkOutput("ar_in_wait", 32'(out_instr_ready), 32'd0);
      #2 in_clr = 1'b0;
      #1;
      checkOutput("ar_ready", 32'(out_instr_ready), 32'd1);
      checkOutput("ar_opv", 32'(out_op_valid), 32'd0);
      checkOutput("ar_opA", out_opA, 32'd0);
      checkOutput("ar_opB", out_opB, 32'd0);
      checkOutput("ar_cdata", out_Cdata, 32'd0);
      checkOutput("ar_csel", 32'(out_Cselect), 32'd0);
      checkOutput("ar_opcode", 32'(out_opcode), 32'd0);
      checkOutput("ar_write", 32'(out_write), 32'd0);
      @(negedge in_clk);
      in_clr          = 1'b1;
      in_result       = 32'd77;
      in_result_valid = 1'b1;
      @(negedge in_clk);
      in_result_valid = 1'b0;
      checkOutput("ar_late_write", 32'(out_write), 32'd0);
      checkOutput("ar_late_cdata", out_Cdata, 32'd0);
      checkOutput("ar_late_ready", 32'(out_instr_ready), 32'd1);
      @(negedge in_clk);
      checkOutput("ar_late_write2", 32'(out_write), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/operand_fetch_seq.md
Name: operand_fetch_seq

Overview:
- Sequencer upstream and downstream of the 16x32 register file.
- Accepts one instruction at a time.
- Reads its source operands one at a time through the file's single A read port, then presents them to the ALU.
- Waits for the ALU result and writes it back through the C write port.
- Lets a one-read-port register file serve two-operand instructions.

Parameters:
DATA_W, 32, operand/result data width
SEL_W, 4, register select width (16 registers)
IMM_W, 19, immediate field width in I-format instructions
IMM_OP_LO, 5'd12, lowest I-format opcode
IMM_OP_HI, 5'd14, highest I-format opcode
R_OP_HI, 5'd11, highest R-format opcode (R-format = 0..R_OP_HI)

Ports:
in_clk  input  1  clock; all state changes on rising edge
in_clr  input  1  asynchronous active-low reset (0 = reset)
in_instr  input  32  instruction; opcode[31:27], ra[26:23], rb[22:19], rc[18:15], C[18:0]
in_instr_valid  input  1  in_instr is valid
out_instr_ready  output  1  block can accept an instruction
out_Aselect  output  SEL_W  read-port select to register file
in_Adata  input  DATA_W  combinational read data from register file
out_opA  output  DATA_W  first operand (reg rb)
out_opB  output  DATA_W  second operand (reg rc or sign-extended C)
out_opcode  output  5  latched opcode to ALU
out_op_valid  output  1  operands valid for ALU
in_op_ready  input  1  ALU accepts operands
in_result  input  DATA_W  ALU result
in_result_valid  input  1  result valid (single-cycle pulse or held)
out_Cdata  output  DATA_W  write-back data
out_Cselect  output  SEL_W  write-back register (ra)
out_write  output  1  write strobe, one cycle
out_illegal  output  1  one-cycle pulse: unsupported opcode dropped

Behaviour:
- Reset: state IDLE. out_instr_ready=1. out_op_valid, out_write and out_illegal=0. All data and select outputs=0. Reset is asynchronous and applies from any state, discarding any in-flight instruction.
- States: IDLE, READ_B, READ_C, ISSUE, WAIT_RES, WRITE.
- IDLE: out_instr_ready=1.
  - in_instr_valid=1 at an edge: latch opcode, ra, rb, rc, C.
  - Opcode R-format or I-format: go to READ_B.
  - Any other opcode: pulse out_illegal for the next cycle and stay in IDLE.
- out_instr_ready=0 in every state except IDLE.
- READ_B: out_Aselect=rb. Latch in_Adata into out_opA at the edge.
  - R-format: go to READ_C.
  - I-format: latch sign-extended C (bit 18 replicated to DATA_W) into out_opB and go to ISSUE.
- READ_C: out_Aselect=rc. Latch in_Adata into out_opB. Go to ISSUE.
- out_Aselect=0 in all states other than READ_B and READ_C.
- rb or rc = 0 needs no special handling; the register file returns 0.
- ISSUE: out_op_valid=1. opA, opB and opcode are held stable until in_op_ready=1 at an edge, then go to WAIT_RES.
- WAIT_RES: wait for in_result_valid=1 at an edge, then latch in_result into out_Cdata and go to WRITE. in_result_valid is ignored in all other states, including the ISSUE accept cycle.
- WRITE: out_Cselect=ra and out_write=1 for exactly one cycle, then return to IDLE.
  - If ra=0, out_write stays 0 (writes to R0 are suppressed) and the FSM still returns to IDLE.
- Latency with no backpressure:
  - R-format: out_op_valid asserts 3 cycles after the accept edge.
  - I-format: out_op_valid asserts 2 cycles after the accept edge.
  - out_write asserts 1 cycle after the result edge.
- Throughput: one instruction in flight. Back-to-back accept is possible the cycle after WRITE.
- out_Cselect and out_Cdata hold their last values outside WRITE; only out_write qualifies them.

Test Plan:
- Reset, then R-format (opcode 3, ra=3, rb=1, rc=2) with R1=5 and R2=7 in file -> out_Aselect=1 then 2 on consecutive cycles. opA=5, opB=7, op_valid 3 cycles after accept. Result 12 returned -> out_write=1 one cycle, Cselect=3, Cdata=12.
- I-format (opcode 12, ra=4, rb=1, C=0x7FFFF) -> only one read (Aselect=1). opB=0xFFFFFFFF, op_valid 2 cycles after accept. With C=0x00005, opB=0x00000005.
- in_op_ready held 0 for 3 cycles in ISSUE -> op_valid stays 1 and opA/opB stable. in_result_valid pulsed during ISSUE is ignored. No write occurs until a later result in WAIT_RES.
- Instruction with ra=0 and rb=0 -> opA=0, full sequence runs, out_write never asserts, FSM back in IDLE (out_instr_ready=1).
- Opcode 5'd20 presented -> out_illegal one-cycle pulse, no Aselect activity, out_instr_ready stays 1.
- in_clr driven low mid-cycle in WAIT_RES -> all outputs 0 and out_instr_ready=1 immediately, without a clock edge. A result arriving after release is ignored and out_write stays 0.
